// File: rtl/display_arb_pkg.sv
// Shared types and defaults for the display arbiter.
package display_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWNED  = 2'd1,
    LINGER = 2'd2
  } arb_state_t;

  // Defaults for a 50 MHz clock: 1 s minimum hold, 4 s slice.
  localparam int unsigned DEF_HOLD_CYCLES    = 50_000_000;
  localparam int unsigned DEF_QUANTUM_CYCLES = 200_000_000;
  localparam int unsigned DEF_CNT_W          = 28;

  // Requester slot assignment on the display path.
  localparam int unsigned REQ_ACCESS = 0;
  localparam int unsigned REQ_GAME   = 1;
  localparam int unsigned REQ_SCORE  = 2;

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Round-robin picker: first requester at or above ptr (wrapping) that is not excluded.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan NUM_REQ slots starting at ptr; the first eligible one wins.
  always_comb begin
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx] && !excl[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Time-shares the 7-segment display word between requesters with round-robin
// grant, a minimum on-screen hold and optional time-slice preemption.
module display_arbiter
  import display_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned QUANTUM_CYCLES = DEF_QUANTUM_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           disp_data,
  output logic                        disp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  owner
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_d;
  logic [DATA_W-1:0]   data_d;
  logic                valid_d;
  logic [IDX_W-1:0]    owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic                take;
  logic                hold_done;
  logic                quantum_up;
  logic [DATA_W-1:0]   words [NUM_REQ];

  // Unpack the flat requester bus into one word per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Current owner is excluded so a preemption always moves to someone else.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .excl  (gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Saturating so a long hold never wraps back under the hold threshold.
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign hold_done  = (cnt_q >= CNT_W'(HOLD_CYCLES));
  assign quantum_up = (QUANTUM_CYCLES != 0) && (cnt_q >= CNT_W'(QUANTUM_CYCLES));

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    data_d  = disp_data;
    owner_d = owner;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        take  = pick_found;
      end
      OWNED: begin
        cnt_d = cnt_inc;
        if (!req[owner]) begin
          if (hold_done) begin
            state_d = IDLE;
            gnt_d   = '0;
          end else begin
            state_d = LINGER;
          end
        end else if (quantum_up && pick_found) begin
          take = 1'b1;
        end else begin
          data_d = words[owner];
        end
      end
      LINGER: begin
        cnt_d = cnt_inc;
        if (req[owner]) begin
          state_d = OWNED;
        end else if (hold_done) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    if (take) begin
      state_d         = OWNED;
      gnt_d           = '0;
      gnt_d[pick_idx] = 1'b1;
      owner_d         = pick_idx;
      data_d          = words[pick_idx];
      cnt_d           = CNT_W'(1);
      ptr_d           = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
    valid_d = |gnt_d;
  end

  // State, counter, pointer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt        <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      owner      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt        <= gnt_d;
      disp_data  <= data_d;
      disp_valid <= valid_d;
      owner      <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter (HOLD=4, QUANTUM=8, NUM_REQ=3).
module tb_display_arbiter;

  localparam int unsigned N     = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned QUANT = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned STARVE_MAX = 2 * QUANT + N;

  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h2222_2222;
  localparam logic [31:0] W2 = 32'h3333_3333;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;

  logic [N-1:0]  gnt, gnt_nq;
  logic [DW-1:0] disp_data, data_nq;
  logic          disp_valid, valid_nq;
  logic [1:0]    owner, owner_nq;

  int n_cmp = 0;
  int n_bad = 0;
  int vec_no = 0;

  typedef struct {
    logic [2:0]  req;
    logic [31:0] w1;
    logic [2:0]  gnt;
    logic [31:0] data;
    logic        dc;
    logic [2:0]  nq_gnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  display_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .HOLD_CYCLES(HOLD), .QUANTUM_CYCLES(QUANT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .disp_data(disp_data), .disp_valid(disp_valid), .owner(owner)
  );

  display_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .HOLD_CYCLES(HOLD), .QUANTUM_CYCLES(0), .CNT_W(CW)
  ) dut_nq (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt_nq), .disp_data(data_nq), .disp_valid(valid_nq), .owner(owner_nq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic [2:0] r, input logic [31:0] w1,
                     input logic [2:0] g, input logic [31:0] d, input logic dc,
                     input logic [2:0] nqg);
    vec_t v;
    v.req = r; v.w1 = w1; v.gnt = g; v.data = d; v.dc = dc; v.nq_gnt = nqg;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive each vector before an edge, queue its expectation, compare after the edge.
  task automatic run_vecs();
    vec_t v, e;
    logic [1:0] idx;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      req      = v.req;
      req_data = {W2, v.w1, W0};
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      vec_no++;
      chk($sformatf("vec%0d gnt", vec_no), 32'(gnt), 32'(e.gnt));
      chk($sformatf("vec%0d valid", vec_no), 32'(disp_valid), 32'(|e.gnt));
      if (!e.dc) chk($sformatf("vec%0d data", vec_no), disp_data, e.data);
      if (e.gnt != 3'b000) begin
        idx = e.gnt[2] ? 2'd2 : (e.gnt[1] ? 2'd1 : 2'd0);
        chk($sformatf("vec%0d owner", vec_no), 32'(owner), 32'(idx));
      end
      chk($sformatf("vec%0d nq_gnt", vec_no), 32'(gnt_nq), 32'(e.nq_gnt));
    end
    vecs.delete();
  endtask

  int wait_cnt [N];
  logic [N-1:0] prev_gnt;
  int run_len;

  initial begin
    // Reset values with no request.
    repeat (2) @(negedge clk);
    chk("rst gnt", 32'(gnt), 32'd0);
    chk("rst valid", 32'(disp_valid), 32'd0);
    chk("rst data", disp_data, 32'd0);
    chk("rst owner", 32'(owner), 32'd0);
    chk("rst nq gnt", 32'(gnt_nq), 32'd0);
    rst = 1'b1;

    // All three requesting, each released two cycles after its grant.
    add(2, 3'b111, W1, 3'b001, W0, 1'b0, 3'b001);
    add(2, 3'b110, W1, 3'b001, W0, 1'b0, 3'b001);
    add(1, 3'b110, W1, 3'b000, W0, 1'b0, 3'b000);
    add(2, 3'b110, W1, 3'b010, W1, 1'b0, 3'b010);
    add(2, 3'b100, W1, 3'b010, W1, 1'b0, 3'b010);
    add(1, 3'b100, W1, 3'b000, W1, 1'b0, 3'b000);
    add(2, 3'b100, W1, 3'b100, W2, 1'b0, 3'b100);
    add(2, 3'b000, W1, 3'b100, W2, 1'b0, 3'b100);
    add(2, 3'b000, W1, 3'b000, W2, 1'b0, 3'b000);
    // One-cycle pulse on requester 1; word changes afterwards but stays frozen.
    add(1, 3'b010, 32'h0000_1234, 3'b010, 32'h0000_1234, 1'b0, 3'b010);
    add(3, 3'b000, 32'hDEAD_BEEF, 3'b010, 32'h0000_1234, 1'b0, 3'b010);
    add(1, 3'b000, 32'hDEAD_BEEF, 3'b000, 32'h0000_1234, 1'b0, 3'b000);
    // Owner 1 drops at cnt=2, reasserts at cnt=3, then tracks the live word.
    add(1, 3'b010, 32'hAAAA_0001, 3'b010, 32'hAAAA_0001, 1'b0, 3'b010);
    add(1, 3'b010, 32'hAAAA_0002, 3'b010, 32'hAAAA_0002, 1'b0, 3'b010);
    add(1, 3'b000, 32'hAAAA_0003, 3'b010, 32'hAAAA_0002, 1'b0, 3'b010);
    add(1, 3'b010, 32'hAAAA_0004, 3'b010, 32'h0, 1'b1, 3'b010);
    add(1, 3'b010, 32'hAAAA_0005, 3'b010, 32'hAAAA_0005, 1'b0, 3'b010);
    add(1, 3'b010, 32'hAAAA_0006, 3'b010, 32'hAAAA_0006, 1'b0, 3'b010);
    add(2, 3'b000, 32'hAAAA_0007, 3'b000, 32'hAAAA_0006, 1'b0, 3'b000);
    // Requester 0 holds, 2 joins at cycle 3: preempted at cnt=8 (never with QUANTUM=0).
    // The no-quantum copy also runs its counter into saturation before release.
    add(2, 3'b001, W1, 3'b001, W0, 1'b0, 3'b001);
    add(6, 3'b101, W1, 3'b001, W0, 1'b0, 3'b001);
    add(8, 3'b101, W1, 3'b100, W2, 1'b0, 3'b001);
    add(1, 3'b101, W1, 3'b001, W0, 1'b0, 3'b001);
    add(3, 3'b000, W1, 3'b001, W0, 1'b0, 3'b000);
    add(1, 3'b000, W1, 3'b000, W0, 1'b0, 3'b000);
    // Grant 1 from ptr=1, leaving ptr=2 before the mid-grant reset.
    add(1, 3'b010, W1, 3'b010, W1, 1'b0, 3'b010);
    run_vecs();

    // Asynchronous reset mid-grant clears outputs before any clock edge.
    #3;
    rst = 1'b0;
    #1;
    chk("arst gnt", 32'(gnt), 32'd0);
    chk("arst valid", 32'(disp_valid), 32'd0);
    chk("arst data", disp_data, 32'd0);
    chk("arst owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    // Pointer restarts at 0: with req=110 requester 1 wins, not 2.
    add(1, 3'b110, W1, 3'b010, W1, 1'b0, 3'b010);
    add(1, 3'b000, W1, 3'b010, W1, 1'b0, 3'b010);
    run_vecs();
    repeat (6) @(negedge clk);

    // Random traffic with invariant, minimum-hold and starvation checks.
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    prev_gnt = gnt;
    run_len  = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      req_data = {$urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      chk("rand onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("rand valid", 32'(disp_valid), 32'(|gnt));
      if (gnt == prev_gnt) begin
        run_len++;
      end else begin
        if (prev_gnt != '0) chk("rand hold_len", 32'(run_len >= int'(HOLD)), 32'd1);
        prev_gnt = gnt;
        run_len  = 1;
      end
      for (int i = 0; i < N; i++) begin
        if (req[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        chk($sformatf("rand starve%0d", i), 32'(wait_cnt[i] > int'(STARVE_MAX)), 32'd0);
      end
    end
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
